hdmi_timing_ctrl: RTL
=====================

// Module: hdmi_timing_ctrl
// PURPOSE
//  Video timing controller/sequencer for the HDMI colour-bar path. Runs horizontal/vertical counters,
//  requests pixels from the pattern source one cycle ahead, and emits aligned hsync/vsync/de/rgb
//  to the TMDS encoder stage. Starts and stops only on frame boundaries under an enable handshake.
// PARAMETERS
//  H_SYNC    96   hsync width, pixel clocks
//  H_BACK    48   horizontal back porch
//  H_ACTIVE  640  active pixels per line
//  H_FRONT   16   horizontal front porch
//  V_SYNC    2    vsync width, lines
//  V_BACK    33   vertical back porch
//  V_ACTIVE  480  active lines
//  V_FRONT   10   vertical front porch
//  SYNC_POL  0    sync active level (0 = active-low, 1 = active-high)
// PORTS
//  sys_clk      in   1   pixel clock, single clock domain
//  sys_rst      in   1   asynchronous, active-high reset
//  enable       in   1   request to run timing; sampled every cycle
//  pix_data     in   24  RGB888 from source, valid 1 cycle after pix_req
//  pix_req      out  1   pixel request; pix_x/pix_y valid in the same cycle
//  pix_x        out  12  active column 0..H_ACTIVE-1 (0 when pix_req=0)
//  pix_y        out  12  active row 0..V_ACTIVE-1 (0 when pix_req=0)
//  frame_start  out  1   1-cycle pulse at h_cnt=0, v_cnt=0 of each frame
//  busy         out  1   high in RUN or DRAIN
//  vid_hsync    out  1   to encoder
//  vid_vsync    out  1   to encoder
//  vid_de       out  1   data enable, to encoder
//  vid_rgb      out  24  pixel to encoder; forced 0 when vid_de=0
// BEHAVIOUR
//  - Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
//  - Counters are 12 bit. h_cnt wraps at H_TOTAL-1 -> 0 and increments v_cnt; v_cnt wraps at V_TOTAL-1 -> 0.
//  - Region decode on the counters (stage 0):
//      hsync active when h_cnt < H_SYNC; vsync active when v_cnt < V_SYNC.
//      active when h_cnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) and
//      v_cnt is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
//  - pix_req, pix_x, pix_y: combinational from stage 0, gated by RUN/DRAIN.
//  - Stage 1: sync/de registered; pix_data sampled. Stage 2: vid_* registered.
//    Video output latency is 2 cycles from the counters, i.e. 1 cycle after pix_data capture.
//  - FSM:
//      IDLE:  counters held at 0. Goes to RUN when enable=1; frame_start pulses on the first RUN cycle.
//      RUN:   counters advance. Goes to DRAIN when enable=0.
//      DRAIN: counters advance to the end of the frame. At h=H_TOTAL-1, v=V_TOTAL-1 goes to IDLE,
//             unless enable=1, which returns to RUN with no gap.
//      enable=1 during DRAIN (before frame end) returns to RUN without reset of the counters.
//  - Frames are never truncated by enable. A partial frame is only possible through sys_rst.
//  - Outside RUN/DRAIN, after the 2-cycle flush:
//      vid_hsync = vid_vsync = ~SYNC_POL (inactive level), vid_de = 0, vid_rgb = 0, pix_req = 0.
//  - Reset values: FSM=IDLE; counters=0; pix_req=0; pix_x=pix_y=0; frame_start=0; busy=0;
//    vid_de=0; vid_rgb=0; vid_hsync=vid_vsync=~SYNC_POL. Reset is effective mid-frame immediately.
//  - frame_start and the DRAIN->IDLE transition in the same cycle as enable rising:
//    stay in RUN and pulse frame_start normally.
// STRUCTURE
//  - Package hdmi_timing_pkg: default 640x480@60 timing constants, RGB_W=24, CNT_W=12, FSM state encoding.
//  - Sub-module hdmi_timing_cnt: h/v counter pair with run/clear inputs and wrap flags.
//    FSM, region decode and output pipeline stay in the top module.
// TESTING
//  1. Reset held 200 ns, enable=0 -> all outputs at reset values; vid_hsync=vid_vsync=1 (SYNC_POL=0).
//  2. enable=1 for 2 frames -> frame_start every 420000 cycles; hsync low for 96 clk per 800;
//     vsync low for 2 lines per 525; 640 de cycles per line; 480 de lines per frame.
//  3. pix_data = {pix_x[7:0], pix_y[7:0], 8'hA5} model with 1-cycle latency ->
//     first vid_de pixel = 24'h0000A5; last pixel of line 0 = 24'h7F00A5.
//  4. enable dropped at v_cnt=100 -> frame completes to v=524, h=799, then IDLE; busy=0; no further de.
//  5. enable dropped at v=100 and re-raised at v=300 -> no gap; next frame_start exactly 420000 cycles
//     after the previous one.
//  6. sys_rst pulsed at h=400, v=200 -> outputs at reset values within the same cycle;
//     with enable still 1, restart at h=0, v=0 with a frame_start pulse.

Source files
------------

// File: rtl/hdmi_timing_pkg.sv
// Shared constants, FSM encoding and stage bundle for the HDMI timing path.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package hdmi_timing_pkg;

    localparam int CNT_W = 12;
    localparam int RGB_W = 24;

    localparam int H_SYNC_D   = 96;
    localparam int H_BACK_D   = 48;
    localparam int H_ACTIVE_D = 640;
    localparam int H_FRONT_D  = 16;
    localparam int V_SYNC_D   = 2;
    localparam int V_BACK_D   = 33;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FRONT_D  = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_t;

    function automatic logic in_window(
        input logic [CNT_W-1:0] cnt,
        input int               lo,
        input int               len
    );
        return (cnt >= CNT_W'(lo)) && (cnt < CNT_W'(lo + len));
    endfunction

endpackage

// File: rtl/hdmi_timing_cnt.sv
// Horizontal/vertical raster counter pair.
// Held at zero while cleared; wrap flags mark the last column/line.
module hdmi_timing_cnt
    import hdmi_timing_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clear,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             h_wrap,
    output logic             v_wrap
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (clear) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (run) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + ONE;
            end else begin
                h_cnt <= h_cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Video timing sequencer: frame-aligned start/stop FSM, region decode,
// one-ahead pixel request and a 2-stage output pipeline to the encoder.
module hdmi_timing_ctrl
    import hdmi_timing_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BACK   = H_BACK_D,
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FRONT  = H_FRONT_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BACK   = V_BACK_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FRONT  = V_FRONT_D,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             enable,
    input  logic [RGB_W-1:0] pix_data,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start,
    output logic             busy,
    output logic             vid_hsync,
    output logic             vid_vsync,
    output logic             vid_de,
    output logic [RGB_W-1:0] vid_rgb
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_OFS      = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] V_OFS      = CNT_W'(V_START);

    localparam sync_t SYNC_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, de: 1'b0};

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             running;
    logic             frame_end;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_act;
    logic             v_act;
    sync_t            s0;
    sync_t            s1;

    assign running   = (state != ST_IDLE);
    assign frame_end = h_wrap & v_wrap;

    hdmi_timing_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_cnt (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .run    (running),
        .clear  (~running),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .h_wrap (h_wrap),
        .v_wrap (v_wrap)
    );

    // Enable only decides what happens at the next frame boundary;
    // it never cuts the raster short.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_RUN;
            end
            ST_RUN, ST_DRAIN: begin
                if (enable)         state_nxt = ST_RUN;
                else if (frame_end) state_nxt = ST_IDLE;
                else                state_nxt = ST_DRAIN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    assign h_act = in_window(h_cnt, H_START, H_ACTIVE);
    assign v_act = in_window(v_cnt, V_START, V_ACTIVE);

    assign pix_req     = running && h_act && v_act;
    assign pix_x       = pix_req ? h_cnt - H_OFS : '0;
    assign pix_y       = pix_req ? v_cnt - V_OFS : '0;
    assign frame_start = running && (h_cnt == '0) && (v_cnt == '0);
    assign busy        = running;

    assign s0.hsync = (running && (h_cnt < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    assign s0.vsync = (running && (v_cnt < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    assign s0.de    = pix_req;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) s1 <= SYNC_IDLE;
        else         s1 <= s0;
    end

    // pix_data arrives during stage 1, answering last cycle's request.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vid_hsync <= ~SYNC_POL;
            vid_vsync <= ~SYNC_POL;
            vid_de    <= 1'b0;
            vid_rgb   <= '0;
        end else begin
            vid_hsync <= s1.hsync;
            vid_vsync <= s1.vsync;
            vid_de    <= s1.de;
            vid_rgb   <= s1.de ? pix_data : '0;
        end
    end

endmodule
